// File: rtl/fixed_sqrt_arbiter_pkg.sv
// Shared types and sizing helpers for the square-root core arbiter.
// The Fixed.Value word is 32 bits with 16 fractional bits.
package fixed_sqrt_arbiter_pkg;

   localparam int FIXED_WIDTH = 32;
   localparam int FIXED_FRAC  = 16;

   typedef logic [FIXED_WIDTH-1:0] fixed_t;

   typedef enum logic [2:0] {
      S_DRAIN,
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   function automatic int tag_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // The timeout timer and the drain counter share one register.
   function automatic int cnt_w(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/fixed_sqrt_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping, reported as a one-hot grant and as an index.
module rr_picker
   import fixed_sqrt_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int TW = tag_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [TW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [TW-1:0] idx,
   output logic          any
);

   always_comb begin
      int p;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      p     = 0;
      for (int k = 0; k < N; k++) begin
         p = (int'(ptr) + k) % N;
         if (!any && req[p]) begin
            any      = 1'b1;
            grant[p] = 1'b1;
            idx      = TW'(p);
         end
      end
   end

endmodule

// File: rtl/fixed_sqrt_arbiter.sv
// Shares a single fixed-point square-root core among N_REQ requesters with
// round-robin grant, one operation in flight and a timeout/drain recovery path.
module fixed_sqrt_arbiter
   import fixed_sqrt_arbiter_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int WIDTH        = FIXED_WIDTH,
   parameter int TIMEOUT      = 64,
   parameter int DRAIN_CYCLES = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_rad,
   output logic [N_REQ-1:0]       ack,
   output logic [N_REQ-1:0]       resp_valid,
   output logic [WIDTH-1:0]       resp_root,
   output logic                   resp_err,
   output logic                   busy,
   output logic                   sqrt_strobe,
   output logic [WIDTH-1:0]       sqrt_rad,
   input  logic                   sqrt_valid,
   input  logic [WIDTH-1:0]       sqrt_root
);

   localparam int TAG_W = tag_w(N_REQ);
   localparam int CNT_W = cnt_w(TIMEOUT, DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [TAG_W-1:0] TAG_LAST     = TAG_W'(N_REQ - 1);

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt;
   logic [TAG_W-1:0]   tag;
   logic [TAG_W-1:0]   rr_ptr;
   logic [WIDTH-1:0]   rad_q;
   logic [WIDTH-1:0]   rad_sel;
   logic [N_REQ-1:0]   grant;
   logic [TAG_W-1:0]   pick_idx;
   logic               pick_any;
   logic               timed_out;

   rr_picker #(
      .N  (N_REQ),
      .TW (TAG_W)
   ) u_picker (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      rad_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) rad_sel = rad_sel | req_rad[i*WIDTH +: WIDTH];
      end
   end

   // A valid arriving on the last timer cycle still wins over the timeout.
   assign timed_out = (state == S_WAIT) && !sqrt_valid && (cnt == TIMEOUT_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= S_DRAIN;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_DRAIN: if (cnt == DRAIN_LAST) state_next = S_IDLE;
         S_IDLE:  if (pick_any) state_next = S_ISSUE;
         S_ISSUE: state_next = S_WAIT;
         S_WAIT:  if (sqrt_valid || timed_out) state_next = S_RESP;
         S_RESP:  state_next = resp_err ? S_DRAIN : S_IDLE;
         default: state_next = S_DRAIN;
      endcase
   end

   always_comb begin
      ack         = '0;
      resp_valid  = '0;
      sqrt_strobe = 1'b0;
      sqrt_rad    = '0;
      busy        = (state != S_IDLE);
      case (state)
         S_ISSUE: begin
            sqrt_strobe = 1'b1;
            sqrt_rad    = rad_q;
            ack[tag]    = 1'b1;
         end
         S_RESP:  resp_valid[tag] = 1'b1;
         default: ;
      endcase
   end

   // Counter, pointer and result registers; tag and radicand only matter once latched.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         rr_ptr    <= '0;
         resp_root <= '0;
         resp_err  <= 1'b0;
      end else begin
         case (state)
            S_DRAIN: cnt <= cnt + 1'b1;
            S_IDLE: begin
               if (pick_any) begin
                  tag   <= pick_idx;
                  rad_q <= rad_sel;
               end
            end
            S_ISSUE: cnt <= '0;
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               if (sqrt_valid) begin
                  resp_root <= sqrt_root;
                  resp_err  <= 1'b0;
               end else if (timed_out) begin
                  resp_root <= '0;
                  resp_err  <= 1'b1;
               end
            end
            S_RESP: begin
               cnt    <= '0;
               rr_ptr <= (tag == TAG_LAST) ? '0 : tag + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
